// File: rtl/td4_control_unit.sv
// td4_control_unit -- fetch/decode/execute sequencer for the TD4 4-bit CPU.
// Fetches an instruction over a req/valid ROM handshake, drives the data
// selector code and immediate, strobes the destination register once per
// instruction and owns the program counter and carry flag.
// Optional build macro TD4_STEP_EN: adds a 'step' input; each pass through
// IDLE needs run=1 and step=1, and every instruction returns to IDLE.
module td4_control_unit #(
   parameter int PC_W  = 4,
   parameter int IMM_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
`ifdef TD4_STEP_EN
   input  logic               step,
`endif
   output logic               rom_req,
   output logic [PC_W-1:0]    rom_addr,
   input  logic [4+IMM_W-1:0] rom_data,
   input  logic               rom_valid,
   input  logic               alu_carry,
   output logic [1:0]         sel,
   output logic [IMM_W-1:0]   imm,
   output logic               load_a,
   output logic               load_b,
   output logic               load_out,
   output logic [PC_W-1:0]    pc,
   output logic               carry,
   output logic               busy,
   output logic               instr_done
);

   localparam int IW = 4 + IMM_W;

   typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXEC} state_t;

   state_t             state_reg, state_next;
   logic [PC_W-1:0]    pc_reg, pc_next;
   logic               carry_reg, carry_next;
   logic [IW-1:0]      ir_reg, ir_next;
   logic [1:0]         sel_reg, sel_next;
   logic [IMM_W-1:0]   imm_reg, imm_next;

   // decoded fields of the instruction register
   logic [1:0]         dec_sel;
   logic               dec_la, dec_lb, dec_lo;
   logic               dec_jmp, dec_jnc, dec_known;

   // start condition out of IDLE and the state that follows EXEC
   logic               start;
   state_t             exec_next;

`ifdef TD4_STEP_EN
   assign start     = run & step;
   assign exec_next = IDLE;
`else
   assign start     = run;
   assign exec_next = run ? FETCH : IDLE;
`endif

   assign rom_addr = pc_reg;
   assign pc       = pc_reg;
   assign carry    = carry_reg;
   assign sel      = sel_reg;
   assign imm      = imm_reg;
   assign busy     = (state_reg != IDLE);

   // opcode decode: selector code, destination strobe and jump kind
   always_comb begin
      dec_sel   = 2'b11;
      dec_la    = 1'b0;
      dec_lb    = 1'b0;
      dec_lo    = 1'b0;
      dec_jmp   = 1'b0;
      dec_jnc   = 1'b0;
      dec_known = 1'b1;
      case (ir_reg[IW-1 -: 4])
         4'b0000: begin dec_sel = 2'b00; dec_la = 1'b1; end  // ADD A,Im
         4'b0101: begin dec_sel = 2'b01; dec_lb = 1'b1; end  // ADD B,Im
         4'b0011: begin dec_sel = 2'b11; dec_la = 1'b1; end  // MOV A,Im
         4'b0111: begin dec_sel = 2'b11; dec_lb = 1'b1; end  // MOV B,Im
         4'b0001: begin dec_sel = 2'b01; dec_la = 1'b1; end  // MOV A,B
         4'b0100: begin dec_sel = 2'b00; dec_lb = 1'b1; end  // MOV B,A
         4'b0010: begin dec_sel = 2'b10; dec_la = 1'b1; end  // IN A
         4'b0110: begin dec_sel = 2'b10; dec_lb = 1'b1; end  // IN B
         4'b1001: begin dec_sel = 2'b01; dec_lo = 1'b1; end  // OUT B
         4'b1011: begin dec_sel = 2'b11; dec_lo = 1'b1; end  // OUT Im
         4'b1111: dec_jmp = 1'b1;                            // JMP Im
         4'b1110: dec_jnc = 1'b1;                            // JNC Im
         default: dec_known = 1'b0;                          // NOP
      endcase
   end

   // sequencer next-state logic and per-state outputs
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      carry_next = carry_reg;
      ir_next    = ir_reg;
      sel_next   = sel_reg;
      imm_next   = imm_reg;
      rom_req    = 1'b0;
      load_a     = 1'b0;
      load_b     = 1'b0;
      load_out   = 1'b0;
      instr_done = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = FETCH;
         end
         FETCH: begin
            rom_req = 1'b1;
            if (rom_valid) begin
               ir_next    = rom_data;
               state_next = DECODE;
            end
         end
         DECODE: begin
            sel_next   = dec_sel;
            imm_next   = ir_reg[IMM_W-1:0];
            state_next = EXEC;
         end
         EXEC: begin
            load_a     = dec_la;
            load_b     = dec_lb;
            load_out   = dec_lo;
            instr_done = 1'b1;
            // JNC tests the carry left by the previous instruction
            carry_next = dec_known ? alu_carry : 1'b0;
            if (dec_jmp || (dec_jnc && !carry_reg))
               pc_next = imm_reg[PC_W-1:0];
            else
               pc_next = pc_reg + PC_W'(1);
            state_next = exec_next;
         end
         default: state_next = IDLE;
      endcase
   end

   // state and datapath-control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         pc_reg    <= '0;
         carry_reg <= 1'b0;
         ir_reg    <= '0;
         sel_reg   <= 2'b00;
         imm_reg   <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         carry_reg <= carry_next;
         ir_reg    <= ir_next;
         sel_reg   <= sel_next;
         imm_reg   <= imm_next;
      end
   end

endmodule

// File: tb/tb_td4_control_unit.sv
// tb_td4_control_unit -- scenario tasks driving td4_control_unit against a
// behavioural instruction-level model of the TD4 sequencer (pc, carry and
// the opcode table), with a ROM responder emulated inside each task.
module tb_td4_control_unit;

   logic       clk;
   logic       rst;
   logic       run;
   logic       step;
   logic       rom_req;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic       rom_valid;
   logic       alu_carry;
   logic [1:0] sel;
   logic [3:0] imm;
   logic       load_a, load_b, load_out;
   logic [3:0] pc;
   logic       carry;
   logic       busy;
   logic       instr_done;

   int vectors;
   int miscompares;
   int done_count;

   // instruction-level model state
   int m_pc;
   int m_carry;

   td4_control_unit #(.PC_W(4), .IMM_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
`ifdef TD4_STEP_EN
      .step       (step),
`endif
      .rom_req    (rom_req),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .rom_valid  (rom_valid),
      .alu_carry  (alu_carry),
      .sel        (sel),
      .imm        (imm),
      .load_a     (load_a),
      .load_b     (load_b),
      .load_out   (load_out),
      .pc         (pc),
      .carry      (carry),
      .busy       (busy),
      .instr_done (instr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (instr_done === 1'b1) done_count <= done_count + 1;

   // Instruction table: selector code, {load_a,load_b,load_out}, and kind
   // (0 = data move, 1 = JMP, 2 = JNC, 3 = undefined/NOP).
   function automatic void ref_decode(input logic [3:0] op, output logic [1:0] s,
                                      output logic [2:0] stb, output int kind);
      kind = 0;
      case (op)
         4'h0: begin s = 2'b00; stb = 3'b100; end
         4'h5: begin s = 2'b01; stb = 3'b010; end
         4'h3: begin s = 2'b11; stb = 3'b100; end
         4'h7: begin s = 2'b11; stb = 3'b010; end
         4'h1: begin s = 2'b01; stb = 3'b100; end
         4'h4: begin s = 2'b00; stb = 3'b010; end
         4'h2: begin s = 2'b10; stb = 3'b100; end
         4'h6: begin s = 2'b10; stb = 3'b010; end
         4'h9: begin s = 2'b01; stb = 3'b001; end
         4'hB: begin s = 2'b11; stb = 3'b001; end
         4'hF: begin s = 2'b11; stb = 3'b000; kind = 1; end
         4'hE: begin s = 2'b11; stb = 3'b000; kind = 2; end
         default: begin s = 2'b11; stb = 3'b000; kind = 3; end
      endcase
   endfunction

   // One complete instruction: waits for the fetch, holds off rom_valid for
   // dly cycles, then follows DECODE and EXEC and checks the architectural
   // result one cycle after EXEC.
   task automatic exec_one(input logic [7:0] instr, input int dly, input logic ac,
                           input bit drop_run, input string tag);
      int         guard;
      logic [1:0] es;
      logic [2:0] estb;
      int         kind;
      int         old_pc;
      guard = 0;
      while (rom_req !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      vectors++;
      if (rom_req !== 1'b1) begin
         miscompares++;
         $display("FAIL %s fetch_start: rom_req=%b required 1", tag, rom_req);
         return;
      end
      vectors++;
      if (rom_addr !== 4'(m_pc)) begin
         miscompares++;
         $display("FAIL %s rom_addr: got %0d required %0d", tag, rom_addr, m_pc);
      end
      for (int i = 0; i < dly; i++) begin
         rom_valid = 1'b0;
         rom_data  = 8'($urandom);
         @(negedge clk);
         vectors++;
         if ({rom_req, rom_addr, load_a, load_b, load_out, instr_done} !== {1'b1, 4'(m_pc), 4'b0000}) begin
            miscompares++;
            $display("FAIL %s fetch_hold: req=%b addr=%0d strobes=%b%b%b done=%b required req=1 addr=%0d no strobes",
                     tag, rom_req, rom_addr, load_a, load_b, load_out, instr_done, m_pc);
         end
      end
      rom_data  = instr;
      rom_valid = 1'b1;
      @(negedge clk);
      // DECODE cycle
      rom_valid = 1'b0;
      rom_data  = 8'($urandom);
      if (drop_run) run = 1'b0;
      vectors++;
      if ({busy, rom_req, load_a, load_b, load_out, instr_done} !== 6'b100000) begin
         miscompares++;
         $display("FAIL %s decode_cycle: busy/req/la/lb/lo/done=%b required 100000", tag,
                  {busy, rom_req, load_a, load_b, load_out, instr_done});
      end
      @(negedge clk);
      // EXEC cycle
      alu_carry = ac;
      ref_decode(instr[7:4], es, estb, kind);
      vectors++;
      if (sel !== es || imm !== instr[3:0]) begin
         miscompares++;
         $display("FAIL %s sel_imm: sel=%b imm=%0h required sel=%b imm=%0h", tag, sel, imm, es, instr[3:0]);
      end
      vectors++;
      if ({load_a, load_b, load_out, instr_done, busy} !== {estb, 2'b11}) begin
         miscompares++;
         $display("FAIL %s exec_strobes: la/lb/lo/done/busy=%b required %b", tag,
                  {load_a, load_b, load_out, instr_done, busy}, {estb, 2'b11});
      end
      old_pc = m_pc;
      if (kind == 1 || (kind == 2 && m_carry == 0)) m_pc = int'(instr[3:0]) % 16;
      else m_pc = (m_pc + 1) % 16;
      m_carry = (kind == 3) ? 0 : int'(ac);
      @(negedge clk);
      alu_carry = 1'($urandom);
      vectors++;
      if (pc !== 4'(m_pc) || carry !== 1'(m_carry)) begin
         miscompares++;
         $display("FAIL %s pc_carry: pc=%0d carry=%b required pc=%0d carry=%0d", tag, pc, carry, m_pc, m_carry);
      end
      vectors++;
`ifdef TD4_STEP_EN
      if ({busy, rom_req, load_a, load_b, load_out, instr_done} !== 6'b000000) begin
`else
      if ({busy, rom_req, load_a, load_b, load_out, instr_done} !== {run, run, 4'b0000}) begin
`endif
         miscompares++;
         $display("FAIL %s after_exec: busy/req/la/lb/lo/done=%b run=%b", tag,
                  {busy, rom_req, load_a, load_b, load_out, instr_done}, run);
      end
      $display("%s: instr=%02h pc %0d->%0d carry=%0d sel=%b", tag, instr, old_pc, m_pc, m_carry, es);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      run = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({pc, carry, sel, imm, busy, rom_req, load_a, load_b, load_out, instr_done} !== 17'd0) begin
         miscompares++;
         $display("FAIL reset_state: pc=%0d carry=%b sel=%b imm=%0h busy=%b req=%b strobes=%b%b%b done=%b required all 0",
                  pc, carry, sel, imm, busy, rom_req, load_a, load_b, load_out, instr_done);
      end
      rst = 1'b0;
      m_pc = 0;
      m_carry = 0;
      $display("reset: pc=%0d carry=%b busy=%b", pc, carry, busy);
   endtask

   task automatic test_mov_imm();
      run = 1'b1;
      exec_one(8'h35, 1, 1'b0, 1'b0, "mov_a_5");
   endtask

   task automatic test_carry_jnc();
      exec_one(8'h0F, 1, 1'b1, 1'b0, "add_a_f");
      exec_one(8'hE3, 1, 1'b0, 1'b0, "jnc_not_taken");
      exec_one(8'hE3, 1, 1'b0, 1'b0, "jnc_taken");
   endtask

   task automatic test_pc_wrap();
      exec_one(8'hFF, 1, 1'b0, 1'b0, "jmp_f");
      exec_one(8'h01, 1, 1'b0, 1'b0, "mov_a_b_wrap");
      exec_one(8'hF7, 1, 1'b1, 1'b0, "jmp_7");
   endtask

   task automatic test_slow_rom_stop();
      exec_one(8'h96, 5, 1'b1, 1'b1, "out_b_slow_stop");
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || rom_req !== 1'b0) begin
         miscompares++;
         $display("FAIL stopped_idle: busy=%b req=%b required 0 0", busy, rom_req);
      end
      run = 1'b1;
   endtask

   task automatic test_nop();
      exec_one(8'h5C, 1, 1'b1, 1'b0, "add_b_c");
      exec_one(8'h8A, 1, 1'b1, 1'b0, "nop_8a");
   endtask

   task automatic test_reset_mid_fetch();
      int guard;
      guard = 0;
      while (rom_req !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({pc, carry, sel, imm, busy, rom_req} !== 14'd0) begin
         miscompares++;
         $display("FAIL reset_mid_fetch: pc=%0d carry=%b sel=%b imm=%0h busy=%b req=%b required all 0",
                  pc, carry, sel, imm, busy, rom_req);
      end
      rst = 1'b0;
      m_pc = 0;
      m_carry = 0;
      $display("reset_mid_fetch: pc=%0d busy=%b", pc, busy);
   endtask

   task automatic test_random();
      logic [7:0] ins;
      for (int n = 0; n < 40; n++) begin
         ins = 8'($urandom_range(0, 255));
         exec_one(ins, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, "random");
      end
   endtask

`ifdef TD4_STEP_EN
   task automatic test_step();
      int before;
      step = 1'b0;
      repeat (3) @(negedge clk);
      before = done_count;
      for (int p = 0; p < 2; p++) begin
         step = 1'b1;
         @(negedge clk);
         step = 1'b0;
         exec_one(8'h3A, 1, 1'b0, 1'b0, "step");
         repeat (3) @(negedge clk);
      end
      vectors++;
      if (done_count - before !== 2) begin
         miscompares++;
         $display("FAIL step_count: got %0d instr_done pulses required 2", done_count - before);
      end
      step = 1'b1;
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      done_count  = 0;
      rst         = 1'b1;
      run         = 1'b0;
      step        = 1'b1;
      rom_valid   = 1'b0;
      rom_data    = 8'h00;
      alu_carry   = 1'b0;
      m_pc        = 0;
      m_carry     = 0;
      test_reset();
      test_mov_imm();
      test_carry_jnc();
      test_pc_wrap();
      test_slow_rom_stop();
      test_nop();
      test_reset_mid_fetch();
      test_random();
`ifdef TD4_STEP_EN
      test_step();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
